// File: rtl/sga_frame_render_if.sv
// ---------------------------------------------------------------------------
// sga_frame_render_if
// Bundles the render request, body-RAM read port and published frame/flags
// of the snake frame renderer.
//   master : the requester side (control unit + body RAM). It drives
//            render_start, snake_size, apple_pos, apple_valid and ram_data.
//   slave  : the renderer. It drives ram_addr, busy, render_done, leds,
//            collision, apple_hit and bad_pos.
// ---------------------------------------------------------------------------
interface sga_frame_render_if #(
    parameter int CELLS  = 36,
    parameter int POS_W  = 6,
    parameter int SIZE_W = 4
);
    logic              render_start;
    logic [SIZE_W-1:0] snake_size;
    logic [POS_W-1:0]  apple_pos;
    logic              apple_valid;
    logic [SIZE_W-1:0] ram_addr;
    logic [POS_W-1:0]  ram_data;
    logic              busy;
    logic              render_done;
    logic [CELLS-1:0]  leds;
    logic              collision;
    logic              apple_hit;
    logic              bad_pos;

    modport master (
        output render_start, snake_size, apple_pos, apple_valid, ram_data,
        input  ram_addr, busy, render_done, leds, collision, apple_hit, bad_pos
    );

    modport slave (
        input  render_start, snake_size, apple_pos, apple_valid, ram_data,
        output ram_addr, busy, render_done, leds, collision, apple_hit, bad_pos
    );
endinterface

// File: rtl/sga_frame_render.sv
// ---------------------------------------------------------------------------
// sga_frame_render
// Reads the first N entries of the snake-body RAM (entry 0 = head), builds a
// CELLS-bit LED frame in a shadow buffer, ORs in the apple and publishes the
// frame plus collision / apple-hit / bad-position flags atomically.
// Ports:
//   clock   : system clock, rising edge
//   restart : asynchronous active-high reset
//   bus     : sga_frame_render_if.slave (request, RAM read port, results)
// ---------------------------------------------------------------------------
module sga_frame_render #(
    parameter int CELLS  = 36,
    parameter int POS_W  = 6,
    parameter int SIZE_W = 4
) (
    input  logic              clock,
    input  logic              restart,
    sga_frame_render_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PRIME, SCAN, FLUSH, PUBLISH} state_t;

    state_t            state_reg;
    logic [SIZE_W-1:0] n_reg;
    logic [POS_W-1:0]  apple_pos_reg;
    logic              apple_valid_reg;
    logic [POS_W-1:0]  head_reg;
    logic [SIZE_W-1:0] scan_idx_reg;
    logic [SIZE_W-1:0] ram_addr_reg;
    logic [CELLS-1:0]  shadow_reg;
    logic              coll_flag_reg;
    logic              bad_flag_reg;
    logic              hit_flag_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [CELLS-1:0]  leds_reg;
    logic              collision_reg;
    logic              apple_hit_reg;
    logic              bad_pos_reg;

    // One-hot decode of the incoming RAM word and of the latched apple.
    // An out-of-range index decodes to all zeros, which doubles as the
    // range check.
    logic [CELLS-1:0]  data_mask;
    logic [CELLS-1:0]  apple_mask;
    logic              data_in_range;
    logic              apple_in_range;
    logic              last_entry;
    logic              addr_more;

    genvar gi;
    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_cell
            assign data_mask[gi]  = (bus.ram_data == POS_W'(gi));
            assign apple_mask[gi] = (apple_pos_reg == POS_W'(gi));
        end
    endgenerate

    assign data_in_range  = |data_mask;
    assign apple_in_range = |apple_mask;
    // Only meaningful while N >= 1, i.e. in PRIME/SCAN.
    assign last_entry     = (scan_idx_reg == n_reg - SIZE_W'(1));
    assign addr_more      = (ram_addr_reg < n_reg - SIZE_W'(1));

    assign bus.ram_addr    = ram_addr_reg;
    assign bus.busy        = busy_reg;
    assign bus.render_done = done_reg;
    assign bus.leds        = leds_reg;
    assign bus.collision   = collision_reg;
    assign bus.apple_hit   = apple_hit_reg;
    assign bus.bad_pos     = bad_pos_reg;

    always_ff @(posedge clock or posedge restart) begin
        if (restart) begin
            state_reg       <= IDLE;
            n_reg           <= '0;
            apple_pos_reg   <= '0;
            apple_valid_reg <= 1'b0;
            head_reg        <= '0;
            scan_idx_reg    <= '0;
            ram_addr_reg    <= '0;
            shadow_reg      <= '0;
            coll_flag_reg   <= 1'b0;
            bad_flag_reg    <= 1'b0;
            hit_flag_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            leds_reg        <= '0;
            collision_reg   <= 1'b0;
            apple_hit_reg   <= 1'b0;
            bad_pos_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // busy is only still high here during the render_done
                    // cycle; a request seen then is dropped, not queued.
                    if (busy_reg) begin
                        busy_reg <= 1'b0;
                    end else if (bus.render_start) begin
                        n_reg           <= bus.snake_size;
                        apple_pos_reg   <= bus.apple_pos;
                        apple_valid_reg <= bus.apple_valid;
                        shadow_reg      <= '0;
                        coll_flag_reg   <= 1'b0;
                        bad_flag_reg    <= 1'b0;
                        hit_flag_reg    <= 1'b0;
                        head_reg        <= '0;
                        scan_idx_reg    <= '0;
                        busy_reg        <= 1'b1;
                        // An empty body never touches the RAM, so the
                        // address is left where the last scan parked it.
                        if (bus.snake_size != '0) begin
                            ram_addr_reg <= '0;
                            state_reg    <= PRIME;
                        end else begin
                            state_reg    <= PUBLISH;
                        end
                    end
                end
                PRIME: begin
                    // Address 0 is in flight; issue address 1 if it exists.
                    if (addr_more)
                        ram_addr_reg <= ram_addr_reg + SIZE_W'(1);
                    state_reg <= SCAN;
                end
                SCAN: begin
                    if (data_in_range)
                        shadow_reg <= shadow_reg | data_mask;
                    else
                        bad_flag_reg <= 1'b1;
                    if (scan_idx_reg == '0)
                        head_reg <= bus.ram_data;
                    else if (bus.ram_data == head_reg)
                        coll_flag_reg <= 1'b1;
                    // Address runs one entry ahead of the consumer and
                    // parks on N-1.
                    if (addr_more)
                        ram_addr_reg <= ram_addr_reg + SIZE_W'(1);
                    if (last_entry)
                        state_reg <= FLUSH;
                    else
                        scan_idx_reg <= scan_idx_reg + SIZE_W'(1);
                end
                FLUSH: begin
                    if (apple_valid_reg) begin
                        if (apple_in_range)
                            shadow_reg <= shadow_reg | apple_mask;
                        else
                            bad_flag_reg <= 1'b1;
                    end
                    hit_flag_reg <= apple_valid_reg && (head_reg == apple_pos_reg);
                    state_reg    <= PUBLISH;
                end
                PUBLISH: begin
                    // With N=0 FLUSH was skipped, so the apple is merged
                    // straight into the published frame here.
                    if (n_reg == '0) begin
                        leds_reg      <= shadow_reg |
                                         (apple_valid_reg ? apple_mask : '0);
                        bad_pos_reg   <= bad_flag_reg |
                                         (apple_valid_reg & ~apple_in_range);
                        apple_hit_reg <= 1'b0;
                    end else begin
                        leds_reg      <= shadow_reg;
                        bad_pos_reg   <= bad_flag_reg;
                        apple_hit_reg <= hit_flag_reg;
                    end
                    collision_reg <= coll_flag_reg;
                    done_reg      <= 1'b1;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sga_frame_render.sv
// ---------------------------------------------------------------------------
// tb_sga_frame_render
// Drives render requests against a small body-RAM model and checks every
// cycle's busy/render_done/leds/flags/ram_addr against a frame-level model
// computed from the rendering rules, plus literal expectations for the
// directed frames.
// ---------------------------------------------------------------------------
module tb_sga_frame_render;
    logic clock   = 1'b0;
    logic restart = 1'b1;

    sga_frame_render_if bus ();

    sga_frame_render dut (
        .clock   (clock),
        .restart (restart),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Body RAM: synchronous read, data one cycle after the address.
    logic [5:0] mem [16];
    always @(posedge clock) bus.ram_data <= mem[bus.ram_addr];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Expected-frame model state
    bit          frame_active = 1'b0;
    int          acc_cyc      = 0;
    int          lat          = 0;
    int          pend_n       = 0;
    logic [35:0] pend_leds    = '0;
    bit          pend_coll    = 1'b0;
    bit          pend_hit     = 1'b0;
    bit          pend_bad     = 1'b0;
    logic [35:0] cur_leds     = '0;
    bit          cur_coll     = 1'b0;
    bit          cur_hit      = 1'b0;
    bit          cur_bad      = 1'b0;
    int          exp_idle_addr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        int k;
        bit exp_busy, exp_done;
        forever begin
            @(negedge clock);
            k = cyc - acc_cyc;
            exp_busy = frame_active && k >= 0 && k <= lat;
            exp_done = frame_active && k == lat;
            if (exp_done) begin
                cur_leds = pend_leds;
                cur_coll = pend_coll;
                cur_hit  = pend_hit;
                cur_bad  = pend_bad;
            end
            check("busy",        64'(bus.busy),        64'(exp_busy));
            check("render_done", 64'(bus.render_done), 64'(exp_done));
            check("leds",        64'(bus.leds),        64'(cur_leds));
            check("collision",   64'(bus.collision),   64'(cur_coll));
            check("apple_hit",   64'(bus.apple_hit),   64'(cur_hit));
            check("bad_pos",     64'(bus.bad_pos),     64'(cur_bad));
            if (frame_active && k >= 0 && pend_n > 0)
                check("ram_addr_bound", 64'(int'(bus.ram_addr) > pend_n - 1), 64'(0));
            else
                check("ram_addr_idle", 64'(bus.ram_addr), 64'(exp_idle_addr));
            if (exp_done) begin
                if (pend_n > 0) exp_idle_addr = pend_n - 1;
                frame_active = 1'b0;
            end
        end
    end

    // Issue a request at a falling edge; returns at the falling edge after
    // the accepting edge, with the request inputs scrambled.
    task automatic launch(input int n, input int apple, input bit av);
        pend_leds = '0;
        pend_coll = 1'b0;
        pend_bad  = 1'b0;
        for (int j = 0; j < n; j++) begin
            if (mem[j] < 36) pend_leds[mem[j]] = 1'b1;
            else             pend_bad = 1'b1;
            if (j > 0 && mem[j] == mem[0]) pend_coll = 1'b1;
        end
        if (av) begin
            if (apple < 36) pend_leds[apple] = 1'b1;
            else            pend_bad = 1'b1;
        end
        pend_hit = (n >= 1) && av && (int'(mem[0]) == apple);
        pend_n   = n;
        lat      = (n == 0) ? 1 : n + 3;
        acc_cyc  = cyc + 1;
        bus.snake_size   = 4'(n);
        bus.apple_pos    = 6'(apple);
        bus.apple_valid  = av;
        bus.render_start = 1'b1;
        frame_active     = 1'b1;
        @(negedge clock);
        bus.render_start = 1'b0;
        bus.snake_size   = 4'($urandom);
        bus.apple_pos    = 6'($urandom);
        bus.apple_valid  = 1'($urandom);
    endtask

    // Wait (bounded by the model's latency) until the falling edge after
    // the done cycle, optionally pulsing render_start while busy.
    task automatic finish_frame(input bit noise);
        int stop_cyc;
        stop_cyc = acc_cyc + lat + 1;
        while (cyc < stop_cyc) begin
            if (noise && cyc <= acc_cyc + lat) bus.render_start = 1'($urandom);
            @(negedge clock);
        end
        bus.render_start = 1'b0;
        $display("frame N=%0d leds=0x%09h coll=%0b hit=%0b bad=%0b done_at=A+%0d",
                 pend_n, bus.leds, bus.collision, bus.apple_hit, bus.bad_pos, lat);
    endtask

    function automatic logic [5:0] rand_cell(input int j);
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)           return 6'($urandom_range(36, 63));
        if (r == 1 && j > 0)  return mem[0];
        return 6'($urandom_range(0, 35));
    endfunction

    initial begin
        int n, apple;
        bit av;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        bus.render_start = 1'b0;
        bus.snake_size   = '0;
        bus.apple_pos    = '0;
        bus.apple_valid  = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_busy", 64'(bus.busy), 64'(0));
        check("reset_leds", 64'(bus.leds), 64'(0));
        check("reset_addr", 64'(bus.ram_addr), 64'(0));
        @(posedge clock);
        #2 restart = 1'b0;
        @(negedge clock);

        // N=3 body + apple on cell 0
        mem[0] = 6'd14; mem[1] = 6'd15; mem[2] = 6'd21;
        launch(3, 0, 1'b1);
        finish_frame(1'b0);
        check("lit_n3_leds", 64'(bus.leds), 64'(36'h0_0020_C001));
        check("lit_n3_flags", 64'({bus.collision, bus.apple_hit, bus.bad_pos}), 64'(0));
        check("lit_n3_addr", 64'(bus.ram_addr), 64'(2));

        // N=0, apple on the last cell; address stays parked
        launch(0, 35, 1'b1);
        finish_frame(1'b0);
        check("lit_n0_leds", 64'(bus.leds), 64'(36'h8_0000_0000));
        check("lit_n0_hit", 64'(bus.apple_hit), 64'(0));
        check("lit_n0_addr", 64'(bus.ram_addr), 64'(2));

        // Collision, then the same body without it
        mem[0] = 6'd7; mem[1] = 6'd8; mem[2] = 6'd9; mem[3] = 6'd7;
        launch(4, 0, 1'b0);
        finish_frame(1'b0);
        check("lit_coll_leds", 64'(bus.leds), 64'(36'h380));
        check("lit_coll", 64'(bus.collision), 64'(1));
        mem[3] = 6'd10;
        launch(4, 0, 1'b0);
        finish_frame(1'b0);
        check("lit_nocoll", 64'(bus.collision), 64'(0));
        check("lit_nocoll_leds", 64'(bus.leds), 64'(36'h780));

        // Out-of-range segment, apple on the head
        mem[0] = 6'd20; mem[1] = 6'd40;
        launch(2, 20, 1'b1);
        finish_frame(1'b0);
        check("lit_bad_leds", 64'(bus.leds), 64'(36'h10_0000));
        check("lit_bad_flags", 64'({bus.apple_hit, bus.bad_pos}), 64'(2'b11));

        // Spurious requests while busy are ignored
        mem[0] = 6'd1; mem[1] = 6'd2; mem[2] = 6'd3;
        launch(3, 5, 1'b1);
        finish_frame(1'b1);
        check("lit_noise_leds", 64'(bus.leds), 64'(36'h2E));

        // Restart in the middle of an N=10 scan
        for (int j = 0; j < 10; j++) mem[j] = rand_cell(j);
        launch(10, 3, 1'b1);
        @(posedge clock);
        @(posedge clock);
        #2 restart = 1'b1;
        frame_active  = 1'b0;
        cur_leds      = '0;
        cur_coll      = 1'b0;
        cur_hit       = 1'b0;
        cur_bad       = 1'b0;
        exp_idle_addr = 0;
        @(posedge clock);
        #2 restart = 1'b0;
        @(negedge clock);
        check("restart_leds", 64'(bus.leds), 64'(0));
        check("restart_busy", 64'(bus.busy), 64'(0));
        $display("restart applied mid-scan");
        launch(10, 3, 1'b1);
        finish_frame(1'b0);

        // Randomised frames
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 15);
            for (int j = 0; j < 16; j++) mem[j] = rand_cell(j);
            apple = ($urandom_range(0, 7) == 0) ? $urandom_range(36, 63)
                                                : $urandom_range(0, 35);
            if ($urandom_range(0, 3) == 0 && n > 0) apple = int'(mem[0]);
            av = 1'($urandom);
            launch(n, apple, av);
            finish_frame(1'($urandom));
        end

        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
